// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the two-port memory arbiter:
//   mem_state_e : arbiter FSM states (IDLE / ACCESS / RESP)
//   port_e      : requester select; the value doubles as the bit index of the
//                 one-hot grant vector produced by rr_arb2
//   CNT_W       : width of the access-latency counter (LATENCY is 1..15)
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the data port and the shared memory port of the
// arbiter.
//
// Handshake: a requester raises ireq/dreq together with its address (and, on
// the data port, dwe/dwdata) and keeps all of them stable until the matching
// ack is high for one cycle; read data is valid in that ack cycle. The
// arbiter samples requests only while idle, so a request still high in the
// ack cycle counts as a fresh request on the next idle cycle. The memory
// side has no back-pressure: memread/memwrite are held for a fixed number of
// cycles and memrdata is sampled on the last of them.
//
// Modports:
//   slave  : arbiter view (requests and memrdata in; acks, read data,
//            memory strobes and busy out)
//   master : environment view (requesters plus memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // fetch port
  logic              ireq;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] irdata;
  logic              iack;

  // data port
  logic              dreq;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dwdata;
  logic [DATA_W-1:0] drdata;
  logic              dack;

  // shared memory port
  logic [ADDR_W-1:0] memaddr;
  logic [DATA_W-1:0] memwdata;
  logic              memread;
  logic              memwrite;
  logic [DATA_W-1:0] memrdata;

  // status
  logic              busy;

  modport slave (
    input  ireq, iaddr,
    output irdata, iack,
    input  dreq, dwe, daddr, dwdata,
    output drdata, dack,
    output memaddr, memwdata, memread, memwrite,
    input  memrdata,
    output busy
  );

  modport master (
    output ireq, iaddr,
    input  irdata, iack,
    output dreq, dwe, daddr, dwdata,
    input  drdata, dack,
    input  memaddr, memwdata, memread, memwrite,
    output memrdata,
    input  busy
  );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant, purely combinational.
//   req_i      : fetch-port request
//   req_d      : data-port request
//   last_grant : port that won the previous arbitration
//   grant      : one-hot grant, bit PORT_I / bit PORT_D; all zero when idle
// On a tie the port that did not win last time is granted; a lone requester
// always wins.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  port_e      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_i && req_d) begin
      if (last_grant == PORT_D) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else if (req_i) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one fixed-latency memory between an instruction-fetch port (read
// only) and a data port (read/write).
//
// Parameters:
//   LATENCY : cycles the memory strobe is held per access (1..15)
//   ADDR_W  : byte-address width (passed to memory unshifted)
//   DATA_W  : data width
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : mem_arbiter_if.slave (requesters, memory port, busy)
//   state_dbg : current FSM state, for observation only
//
// Timing: a request accepted in IDLE at cycle t strobes memory in cycles
// t+1..t+LATENCY and acks in cycle t+LATENCY+1; the FSM is back in IDLE the
// cycle after, giving one access per LATENCY+2 cycles.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output mem_state_e   state_dbg
);

  // The counter starts at LATENCY-1 and the access ends when it reads 0,
  // so the strobe is up for exactly LATENCY cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e        state;
  mem_state_e        state_next;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        grant;
  logic              any_req;
  port_e             win_port;

  port_e             gnt_port;    // port owning the access in flight
  port_e             last_grant;  // round-robin history
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .req_i      (bus.ireq),
    .req_d      (bus.dreq),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign any_req  = |grant;
  assign win_port = grant[1] ? PORT_D : PORT_I;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Strobes exist only in ACCESS, acks only in RESP, so a reset that forces
  // IDLE silences both on the very next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.iack     = 1'b0;
    bus.dack     = 1'b0;
    unique case (state)
      ACCESS: begin
        if (we_q) begin
          bus.memwrite = 1'b1;
        end else begin
          bus.memread = 1'b1;
        end
      end
      RESP: begin
        if (gnt_port == PORT_D) begin
          bus.dack = 1'b1;
        end else begin
          bus.iack = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.memaddr  = addr_q;
  assign bus.memwdata = wdata_q;
  assign bus.irdata   = irdata_q;
  assign bus.drdata   = drdata_q;
  assign state_dbg    = state;

  // ---------------------------------------------------------------------------
  // Datapath: request latch, latency counter, read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      gnt_port   <= PORT_I;
      last_grant <= PORT_D;  // fetch port wins the first tie
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_port   <= win_port;
            last_grant <= win_port;
            cnt        <= CNT_LOAD;
            if (win_port == PORT_D) begin
              addr_q  <= bus.daddr;
              wdata_q <= bus.dwdata;
              we_q    <= bus.dwe;
            end else begin
              // Fetches are always reads; write data keeps its old value.
              addr_q  <= bus.iaddr;
              we_q    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (gnt_port == PORT_D) begin
                drdata_q <= bus.memrdata;
              end else begin
                irdata_q <= bus.memrdata;
              end
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: one instance at LATENCY=2 with a writable memory
// model, one at LATENCY=1 with a read-only memory. Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_state_e state0;
  mem_state_e state1;

  mem_arbiter #(.LATENCY(LAT0), .ADDR_W(32), .DATA_W(32)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .state_dbg (state0)
  );

  mem_arbiter #(.LATENCY(LAT1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .state_dbg (state1)
  );

  // ---------------------------------------------------------------------------
  // Memory models
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input logic [5:0] idx);
    return {16'hC0DE, 10'd0, idx};
  endfunction

  logic [31:0] mem0    [0:63];
  logic [31:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem0[i] <= init_word(6'(i));
    end else if (bus0.memwrite) begin
      mem0[bus0.memaddr[7:2]] <= bus0.memwdata;
    end
  end

  assign bus0.memrdata = mem0[bus0.memaddr[7:2]];
  assign bus1.memrdata = init_word(bus1.memaddr[7:2]);

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    bus0.ireq = 1'b0; bus0.iaddr = '0;
    bus0.dreq = 1'b0; bus0.dwe = 1'b0; bus0.daddr = '0; bus0.dwdata = '0;
    bus1.ireq = 1'b0; bus1.iaddr = '0;
    bus1.dreq = 1'b0; bus1.dwe = 1'b0; bus1.daddr = '0; bus1.dwdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
  endtask

  // Runs one access on dut0 and returns the number of cycles to its ack
  // (-1 if no ack within the bound); ends on the idle cycle after the ack.
  task automatic drive_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int cycles);
    cycles = -1;
    if (is_d) begin
      bus0.dreq = 1'b1; bus0.dwe = we; bus0.daddr = addr; bus0.dwdata = wdata;
    end else begin
      bus0.ireq = 1'b1; bus0.iaddr = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((is_d ? bus0.dack : bus0.iack) === 1'b1) begin
        cycles = c;
        break;
      end
    end
    bus0.ireq = 1'b0; bus0.dreq = 1'b0; bus0.dwe = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lat;
    do_reset();
    drive_txn(1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, lat);
    drive_txn(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat);
    n_checks++;
    if (bus0.drdata !== 32'h1234_5678) begin
      n_errors++; $display("FAIL pre_reset_drdata: got %h want %h", bus0.drdata, 32'h1234_5678);
    end
    drive_txn(1'b0, 1'b0, 32'h0000_0018, 32'h0, lat);
    bus0.ireq = 1'b1; bus0.iaddr = 32'h0000_0008;
    @(negedge clk);
    do_reset();
    n_checks++;
    if (state0 !== IDLE) begin
      n_errors++; $display("FAIL reset_state: got %0d want %0d", state0, IDLE);
    end
    n_checks++;
    if (bus0.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    n_checks++;
    if (bus0.memread !== 1'b0 || bus0.memwrite !== 1'b0) begin
      n_errors++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus0.memread, bus0.memwrite);
    end
    n_checks++;
    if (bus0.iack !== 1'b0 || bus0.dack !== 1'b0) begin
      n_errors++; $display("FAIL reset_acks: got i=%b d=%b want 0 0", bus0.iack, bus0.dack);
    end
    n_checks++;
    if (bus0.irdata !== 32'h0) begin n_errors++; $display("FAIL reset_irdata: got %h want 0", bus0.irdata); end
    n_checks++;
    if (bus0.drdata !== 32'h0) begin n_errors++; $display("FAIL reset_drdata: got %h want 0", bus0.drdata); end
    n_checks++;
    if (bus0.memaddr !== 32'h0) begin n_errors++; $display("FAIL reset_memaddr: got %h want 0", bus0.memaddr); end
    n_checks++;
    if (bus0.memwdata !== 32'h0) begin n_errors++; $display("FAIL reset_memwdata: got %h want 0", bus0.memwdata); end
  endtask

  task automatic test_fetch();
    do_reset();
    bus0.ireq = 1'b1; bus0.iaddr = 32'h0000_0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.memread !== (c <= 2)) begin
        n_errors++; $display("FAIL fetch_memread c=%0d: got %b want %b", c, bus0.memread, (c <= 2));
      end
      n_checks++;
      if (bus0.memwrite !== 1'b0) begin
        n_errors++; $display("FAIL fetch_memwrite c=%0d: got %b want 0", c, bus0.memwrite);
      end
      n_checks++;
      if (bus0.iack !== (c == 3)) begin
        n_errors++; $display("FAIL fetch_iack c=%0d: got %b want %b", c, bus0.iack, (c == 3));
      end
      n_checks++;
      if (bus0.busy !== (c <= 3)) begin
        n_errors++; $display("FAIL fetch_busy c=%0d: got %b want %b", c, bus0.busy, (c <= 3));
      end
      n_checks++;
      if (bus0.memaddr !== 32'h0000_0010) begin
        n_errors++; $display("FAIL fetch_memaddr c=%0d: got %h want 00000010", c, bus0.memaddr);
      end
      if (c == 3) begin
        n_checks++;
        if (bus0.irdata !== init_word(6'd4)) begin
          n_errors++; $display("FAIL fetch_irdata: got %h want %h", bus0.irdata, init_word(6'd4));
        end
        bus0.ireq = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    int lat;
    bus0.dreq = 1'b1; bus0.dwe = 1'b1; bus0.daddr = 32'h0000_0020; bus0.dwdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.memwrite !== (c <= 2) || bus0.memread !== 1'b0) begin
        n_errors++; $display("FAIL write_strobes c=%0d: got wr=%b rd=%b want %b 0", c, bus0.memwrite, bus0.memread, (c <= 2));
      end
      n_checks++;
      if (bus0.dack !== (c == 3)) begin
        n_errors++; $display("FAIL write_dack c=%0d: got %b want %b", c, bus0.dack, (c == 3));
      end
      if (c <= 2) begin
        n_checks++;
        if (bus0.memaddr !== 32'h0000_0020 || bus0.memwdata !== 32'hDEAD_BEEF) begin
          n_errors++; $display("FAIL write_bus c=%0d: got %h/%h want 00000020/deadbeef", c, bus0.memaddr, bus0.memwdata);
        end
      end else begin
        n_checks++;
        if (bus0.drdata !== 32'h0) begin
          n_errors++; $display("FAIL write_drdata_hold: got %h want 0", bus0.drdata);
        end
        bus0.dreq = 1'b0; bus0.dwe = 1'b0;
      end
    end
    @(negedge clk);
    drive_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat);
    n_checks++;
    if (lat !== LAT0 + 1) begin n_errors++; $display("FAIL readback_latency: got %0d want %0d", lat, LAT0 + 1); end
    n_checks++;
    if (bus0.drdata !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL readback_drdata: got %h want deadbeef", bus0.drdata);
    end
  endtask

  task automatic test_alternate();
    bit exp_i, exp_d;
    do_reset();
    bus0.ireq = 1'b1; bus0.iaddr = 32'h0000_0040;
    bus0.dreq = 1'b1; bus0.dwe = 1'b0; bus0.daddr = 32'h0000_0044;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_i = (c % 4 == 3) && ((c / 4) % 2 == 0);
      exp_d = (c % 4 == 3) && ((c / 4) % 2 == 1);
      n_checks++;
      if (bus0.iack !== exp_i || bus0.dack !== exp_d) begin
        n_errors++; $display("FAIL alt_acks c=%0d: got i=%b d=%b want %b %b", c, bus0.iack, bus0.dack, exp_i, exp_d);
      end
      if (exp_i) begin
        n_checks++;
        if (bus0.irdata !== init_word(6'd16)) begin
          n_errors++; $display("FAIL alt_irdata c=%0d: got %h want %h", c, bus0.irdata, init_word(6'd16));
        end
      end
      if (exp_d) begin
        n_checks++;
        if (bus0.drdata !== init_word(6'd17)) begin
          n_errors++; $display("FAIL alt_drdata c=%0d: got %h want %h", c, bus0.drdata, init_word(6'd17));
        end
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus0.ireq = 1'b1; bus0.iaddr = 32'h0000_0008;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus0.memread !== 1'b1 || state0 !== ACCESS) begin
      n_errors++; $display("FAIL midrst_precond: got rd=%b st=%0d want 1 %0d", bus0.memread, state0, ACCESS);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state0 !== IDLE) begin n_errors++; $display("FAIL midrst_state: got %0d want %0d", state0, IDLE); end
    n_checks++;
    if (bus0.memread !== 1'b0 || bus0.memwrite !== 1'b0) begin
      n_errors++; $display("FAIL midrst_strobes: got rd=%b wr=%b want 0 0", bus0.memread, bus0.memwrite);
    end
    n_checks++;
    if (bus0.iack !== 1'b0 || bus0.busy !== 1'b0) begin
      n_errors++; $display("FAIL midrst_ack_busy: got ack=%b busy=%b want 0 0", bus0.iack, bus0.busy);
    end
    reset = 1'b0;
    bus0.ireq = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
    @(negedge clk);
    n_checks++;
    if (bus0.iack !== 1'b0 || bus0.busy !== 1'b0) begin
      n_errors++; $display("FAIL midrst_after: got ack=%b busy=%b want 0 0", bus0.iack, bus0.busy);
    end
  endtask

  task automatic test_latency1();
    bus1.dreq = 1'b1; bus1.dwe = 1'b0; bus1.daddr = 32'h0000_0008;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus1.dreq = 1'b0;
      n_checks++;
      if (bus1.memread !== (c == 1) || bus1.memwrite !== 1'b0) begin
        n_errors++; $display("FAIL lat1_strobes c=%0d: got rd=%b wr=%b want %b 0", c, bus1.memread, bus1.memwrite, (c == 1));
      end
      n_checks++;
      if (bus1.dack !== (c == 2)) begin
        n_errors++; $display("FAIL lat1_dack c=%0d: got %b want %b", c, bus1.dack, (c == 2));
      end
      n_checks++;
      if (bus1.busy !== (c <= 2)) begin
        n_errors++; $display("FAIL lat1_busy c=%0d: got %b want %b", c, bus1.busy, (c <= 2));
      end
      if (c == 2) begin
        n_checks++;
        if (bus1.drdata !== init_word(6'd2)) begin
          n_errors++; $display("FAIL lat1_drdata: got %h want %h", bus1.drdata, init_word(6'd2));
        end
      end
    end
  endtask

  // Random traffic against a transaction-timeline model: each granted access
  // occupies LATENCY strobe cycles, one ack cycle and one idle cycle.
  task automatic test_random();
    int pos;
    bit m_port, m_we, m_last, exp_strobe, exp_ack;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd, exp_data;
    do_reset();
    exp_q.delete();
    pos = 0; m_port = 1'b0; m_we = 1'b0; m_last = 1'b1;
    m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_strobe = (pos >= 1) && (pos <= LAT0);
      exp_ack    = (pos == LAT0 + 1);
      n_checks++;
      if (bus0.memread !== (exp_strobe && !m_we) || bus0.memwrite !== (exp_strobe && m_we)) begin
        n_errors++; $display("FAIL rnd_strobes cyc=%0d: got rd=%b wr=%b want %b %b", cyc, bus0.memread, bus0.memwrite, exp_strobe && !m_we, exp_strobe && m_we);
      end
      n_checks++;
      if (bus0.iack !== (exp_ack && !m_port) || bus0.dack !== (exp_ack && m_port)) begin
        n_errors++; $display("FAIL rnd_acks cyc=%0d: got i=%b d=%b want %b %b", cyc, bus0.iack, bus0.dack, exp_ack && !m_port, exp_ack && m_port);
      end
      n_checks++;
      if (bus0.busy !== (pos != 0)) begin
        n_errors++; $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, bus0.busy, (pos != 0));
      end
      if (exp_strobe) begin
        n_checks++;
        if (bus0.memaddr !== m_addr) begin
          n_errors++; $display("FAIL rnd_memaddr cyc=%0d: got %h want %h", cyc, bus0.memaddr, m_addr);
        end
        if (m_we) begin
          n_checks++;
          if (bus0.memwdata !== m_wdata) begin
            n_errors++; $display("FAIL rnd_memwdata cyc=%0d: got %h want %h", cyc, bus0.memwdata, m_wdata);
          end
        end
      end
      if (exp_ack) begin
        if (m_we) begin
          ref_mem[m_addr[7:2]] = m_wdata;
        end else begin
          exp_data = exp_q.pop_front();
          if (m_port) m_drd = exp_data;
          else m_ird = exp_data;
        end
        if (m_port) begin bus0.dreq = 1'b0; bus0.dwe = 1'b0; end
        else bus0.ireq = 1'b0;
      end
      n_checks++;
      if (bus0.irdata !== m_ird || bus0.drdata !== m_drd) begin
        n_errors++; $display("FAIL rnd_rdata cyc=%0d: got %h/%h want %h/%h", cyc, bus0.irdata, bus0.drdata, m_ird, m_drd);
      end
      // new requests from idle requesters
      if (!bus0.ireq && $urandom_range(0, 3) == 0) begin
        bus0.ireq = 1'b1; bus0.iaddr = $urandom;
      end
      if (!bus0.dreq && $urandom_range(0, 3) == 0) begin
        bus0.dreq = 1'b1; bus0.dwe = 1'($urandom_range(0, 1));
        bus0.daddr = $urandom; bus0.dwdata = $urandom;
      end
      // advance the model with this cycle's inputs
      if (pos == 0) begin
        if (bus0.ireq || bus0.dreq) begin
          m_port = (bus0.ireq && bus0.dreq) ? !m_last : bus0.dreq;
          m_last = m_port;
          m_we   = m_port && bus0.dwe;
          m_addr = m_port ? bus0.daddr : bus0.iaddr;
          if (m_port) m_wdata = bus0.dwdata;
          if (!m_we) exp_q.push_back(ref_mem[m_addr[7:2]]);
          pos = 1;
        end
      end else if (pos == LAT0 + 1) begin
        pos = 0;
      end else begin
        pos++;
      end
      @(negedge clk);
    end
    clear_inputs();
    repeat (LAT0 + 3) @(negedge clk);
    n_checks++;
    if (bus0.busy !== 1'b0) begin n_errors++; $display("FAIL rnd_drain: got busy=%b want 0", bus0.busy); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_write_read();
    test_alternate();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
